// File: rtl/cam_stream_tx.sv
// OV7670-style camera bus transmitter: replays a byte-wide frame memory as pclk/vsync/href/data.
// Optional build macro CAM_TX_TESTPAT_EN adds a test_pattern input that replaces memory data with col^line.
module cam_stream_tx #(
    parameter int H_ACTIVE  = 160,
    parameter int V_ACTIVE  = 120,
    parameter int H_BLANK   = 16,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 2,
    parameter int VFP_LINES = 2,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
`ifdef CAM_TX_TESTPAT_EN
    input  logic              test_pattern,
`endif
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              pclk,
    output logic              vsync,
    output logic              href,
    output logic [7:0]        data
);

    localparam int LINE_LEN = H_ACTIVE + H_BLANK;
    localparam int COL_W    = $clog2(LINE_LEN);
    localparam int LMAX_A   = (V_ACTIVE > VS_LINES) ? V_ACTIVE : VS_LINES;
    localparam int LMAX_B   = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
    localparam int LMAX     = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
    localparam int LINE_W   = (LMAX > 1) ? $clog2(LMAX) : 1;

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

    state_t             state, state_nxt;
    logic [COL_W-1:0]   col, col_nxt;
    logic [LINE_W-1:0]  line, line_nxt;
    logic               rd_slot;
    logic               eof, enter, boundary, href_nxt, rd_nxt;
    logic [7:0]         byte_nxt;

    function automatic logic [LINE_W-1:0] last_line(input state_t s);
        case (s)
            VSYNC:   return LINE_W'(VS_LINES - 1);
            VBP:     return LINE_W'(VBP_LINES - 1);
            ACTIVE:  return LINE_W'(V_ACTIVE - 1);
            default: return LINE_W'(VFP_LINES - 1);
        endcase
    endfunction

    // Position advances once per pclk period, on the edge where pclk falls.
    assign boundary = (state == IDLE) || pclk;

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        line_nxt  = line;
        eof       = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_nxt = VSYNC;
                col_nxt   = '0;
                line_nxt  = '0;
            end
        end else if (pclk) begin
            if (col == COL_W'(LINE_LEN - 1)) begin
                col_nxt = '0;
                if (line == last_line(state)) begin
                    line_nxt = '0;
                    case (state)
                        VSYNC:   state_nxt = VBP;
                        VBP:     state_nxt = ACTIVE;
                        ACTIVE:  state_nxt = VFP;
                        default: begin
                            eof       = 1'b1;
                            state_nxt = continuous ? VSYNC : IDLE;
                        end
                    endcase
                end else begin
                    line_nxt = line + LINE_W'(1);
                end
            end else begin
                col_nxt = col + COL_W'(1);
            end
        end
    end

    assign enter    = ((state == IDLE) && start) || (eof && continuous);
    assign href_nxt = (state_nxt == ACTIVE) && (col_nxt < COL_W'(H_ACTIVE));

    // Read one period ahead so the byte lands in data on the next pclk fall.
    always_comb begin
        rd_nxt = 1'b0;
        if (col_nxt != COL_W'(LINE_LEN - 1))
            rd_nxt = (state_nxt == ACTIVE) && (col_nxt < COL_W'(H_ACTIVE - 1));
        else
            rd_nxt = ((state_nxt == ACTIVE) && (line_nxt != LINE_W'(V_ACTIVE - 1))) ||
                     ((state_nxt == VBP) && (line_nxt == LINE_W'(VBP_LINES - 1)));
    end

`ifdef CAM_TX_TESTPAT_EN
    logic tp_q;
    logic tp_sel;
    assign tp_sel   = enter ? test_pattern : tp_q;
    assign byte_nxt = tp_sel ? (8'(col_nxt) ^ 8'(line_nxt)) : mem_data;
    assign mem_rd   = rd_slot & ~tp_q;
`else
    assign byte_nxt = mem_data;
    assign mem_rd   = rd_slot;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            line       <= '0;
            pclk       <= 1'b0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rd_slot    <= 1'b0;
            data       <= '0;
            mem_addr   <= '0;
`ifdef CAM_TX_TESTPAT_EN
            tp_q       <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            line       <= line_nxt;
            frame_done <= eof;
            busy       <= (state_nxt != IDLE);
            pclk       <= ((state != IDLE) && (state_nxt != IDLE)) ? ~pclk : 1'b0;
            rd_slot    <= 1'b0;
            if (rd_slot)
                mem_addr <= mem_addr + ADDR_W'(1);
            if (boundary) begin
                vsync   <= (state_nxt == VSYNC);
                href    <= href_nxt;
                data    <= href_nxt ? byte_nxt : 8'h00;
                rd_slot <= rd_nxt;
                if (enter) begin
                    mem_addr <= '0;
`ifdef CAM_TX_TESTPAT_EN
                    tp_q     <= test_pattern;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_stream_tx.sv
// Scoreboard bench for cam_stream_tx: expected bytes/addresses are queued, a monitor pops and compares.
module tb_cam_stream_tx;
    localparam int HA = 4, VA = 3, HB = 2, VS = 1, VBP = 1, VFP = 1, AW = 8;

    logic clk = 1'b0;
    logic rst, start, continuous;
`ifdef CAM_TX_TESTPAT_EN
    logic test_pattern;
`endif
    logic busy, frame_done, mem_rd, pclk, vsync, href;
    logic [AW-1:0] mem_addr;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] data;

    cam_stream_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
`ifdef CAM_TX_TESTPAT_EN
        .test_pattern(test_pattern),
`endif
        .busy(busy), .frame_done(frame_done), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .pclk(pclk), .vsync(vsync), .href(href), .data(data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'(8'hA0 + i);
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    int vectors = 0, miscompares = 0;
    logic [7:0]    byte_q[$];
    logic [AW-1:0] addr_q[$];
    int cyc = 0;
    int rd_cnt = 0, vs_cnt = 0, fd_cnt = 0, win_cnt = 0;
    int t_busy = 0, t_fd = 0, t_fd_prev = 0;
    bit href_prev = 0, rd_prev = 0, busy_prev = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one pclk-high sample per pclk period, plus per-clk read strobe checks.
    always @(negedge clk) begin
        if (pclk) begin
            if (vsync) vs_cnt++;
            if (href) begin
                if (!href_prev) win_cnt++;
                if (byte_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL byte: got 0x%0h, expected no byte", data);
                end else chk("byte", 32'(data), 32'(byte_q.pop_front()));
            end else chk("data_idle", 32'(data), 32'h0);
            href_prev = href;
        end
        if (mem_rd) begin
            rd_cnt++;
            chk("mem_rd_width", 32'(rd_prev), 32'h0);
            if (addr_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL mem_rd: got read at 0x%0h, expected no read", mem_addr);
            end else chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        end
        rd_prev = mem_rd;
        if (busy && !busy_prev) t_busy = cyc;
        busy_prev = busy;
        if (frame_done) begin
            fd_cnt++;
            t_fd_prev = t_fd;
            t_fd = cyc;
        end
    end

    task automatic push_frame();
        for (int i = 0; i < HA * VA; i++) begin
            byte_q.push_back(8'(8'hA0 + i));
            addr_q.push_back(AW'(i));
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        bit ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #1;
            if (frame_done) begin ok = 1; break; end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL %s: got no frame_done within %0d clk, expected one", name, bound);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected bench to end");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, vs0, fd0, win0;
        rst = 1'b1; start = 1'b0; continuous = 1'b0;
`ifdef CAM_TX_TESTPAT_EN
        test_pattern = 1'b0;
`endif
        @(negedge clk); start = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", 32'({pclk, vsync, href, mem_rd, busy, frame_done, data, mem_addr}), 32'h0);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("start_in_reset_ignored", 32'({busy, pclk}), 32'h0);

        // Single frame
        push_frame();
        rd0 = rd_cnt; vs0 = vs_cnt; fd0 = fd_cnt; win0 = win_cnt;
        pulse_start();
        wait_done("single_done", 200);
        chk("busy_falls_with_done", 32'(busy), 32'h0);
        chk("frame_len", 32'(t_fd - t_busy), 32'd72);
        repeat (4) @(negedge clk);
        #1;
        chk("vsync_periods", 32'(vs_cnt - vs0), 32'd6);
        chk("href_windows", 32'(win_cnt - win0), 32'd3);
        chk("rd_count", 32'(rd_cnt - rd0), 32'd12);
        chk("done_count", 32'(fd_cnt - fd0), 32'd1);
        chk("bytes_left", 32'(byte_q.size()), 32'h0);
        chk("addrs_left", 32'(addr_q.size()), 32'h0);
        chk("idle_bus", 32'({pclk, vsync, href, busy}), 32'h0);

        // Back-to-back frames
        push_frame(); push_frame();
        rd0 = rd_cnt; vs0 = vs_cnt; fd0 = fd_cnt;
        continuous = 1'b1;
        pulse_start();
        wait_done("b2b_first_done", 200);
        chk("b2b_busy_held", 32'(busy), 32'h1);
        chk("b2b_vsync_restart", 32'({vsync, pclk}), 32'h2);
        continuous = 1'b0;
        @(negedge clk); #1;
        chk("b2b_pclk_no_gap", 32'(pclk), 32'h1);
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second_done", 200);
        chk("b2b_second_len", 32'(t_fd - t_fd_prev), 32'd72);
        chk("b2b_busy_end", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);
        #1;
        chk("mid_start_ignored", 32'(busy), 32'h0);
        chk("b2b_done_count", 32'(fd_cnt - fd0), 32'd2);
        chk("b2b_rd_count", 32'(rd_cnt - rd0), 32'd24);
        chk("b2b_vsync_periods", 32'(vs_cnt - vs0), 32'd12);
        chk("b2b_bytes_left", 32'(byte_q.size()), 32'h0);

        // Abort in the middle of the third active line
        push_frame();
        fd0 = fd_cnt;
        pulse_start();
        repeat (51) @(negedge clk);
        #1;
        chk("abort_in_active", 32'(href), 32'h1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("abort_outputs", 32'({pclk, vsync, href, mem_rd, busy, frame_done, data, mem_addr}), 32'h0);
        rst = 1'b0;
        byte_q.delete(); addr_q.delete();
        repeat (10) @(negedge clk);
        #1;
        chk("abort_no_done", 32'(fd_cnt - fd0), 32'h0);
        push_frame();
        rd0 = rd_cnt;
        pulse_start();
        wait_done("after_abort_done", 200);
        repeat (2) @(negedge clk);
        #1;
        chk("after_abort_rd", 32'(rd_cnt - rd0), 32'd12);
        chk("after_abort_bytes_left", 32'(byte_q.size()), 32'h0);
        chk("after_abort_addrs_left", 32'(addr_q.size()), 32'h0);

`ifdef CAM_TX_TESTPAT_EN
        // Test pattern frame: col ^ line, no memory reads
        for (int l = 0; l < VA; l++)
            for (int c = 0; c < HA; c++)
                byte_q.push_back(8'(c ^ l));
        rd0 = rd_cnt;
        test_pattern = 1'b1;
        pulse_start();
        test_pattern = 1'b0;
        wait_done("testpat_done", 200);
        repeat (2) @(negedge clk);
        #1;
        chk("testpat_no_reads", 32'(rd_cnt - rd0), 32'h0);
        chk("testpat_bytes_left", 32'(byte_q.size()), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
